// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS main controller FSM
module mc_ctrl_fsm #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic               illegal_op
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_R_EXE,
        S_R_WB, S_BEQ, S_JUMP, S_JAL, S_JR, S_I_EXE, S_I_WB
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    function automatic state_t next_of(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:   n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     n = S_MEM_ADR;
                    OP_R:             n = (fn == FN_JR) ? S_JR : S_R_EXE;
                    OP_BEQ:           n = S_BEQ;
                    OP_J:             n = S_JUMP;
                    OP_JAL:           n = S_JAL;
                    OP_ADDI, OP_SLTI: n = S_I_EXE;
                    default:          n = S_FETCH;
                endcase
            end
            S_MEM_ADR: n = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  n = S_LW_WB;
            S_R_EXE:   n = S_R_WB;
            S_I_EXE:   n = S_I_WB;
            default:   n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:  c.alu_src_b = 2'b11;
            S_MEM_ADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEM_RD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_LW_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
            S_MEM_WR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_R_EXE:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_R_WB:    begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
            S_BEQ: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_src = 2'b01;
            end
            S_JUMP:    begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
            S_JAL: begin
                c.pc_write = 1'b1; c.pc_src = 2'b10; c.reg_write = 1'b1;
                c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
            end
            S_JR:      begin c.pc_write = 1'b1; c.pc_src = 2'b11; end
            S_I_EXE: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                c.alu_op = (op == OP_SLTI) ? 2'b11 : 2'b00;
            end
            S_I_WB:    c.reg_write = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_t state;
    state_t nxt;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl;

    assign nxt = next_of(state, opcode, funct);

    // Outputs are registered from the next state; the reset value already
    // holds FETCH's decode so the first edge after release performs the fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            ctrl_q     <= decode(S_FETCH, 6'b000000);
            instr_cnt  <= '0;
            illegal_op <= 1'b0;
        end else begin
            state  <= nxt;
            ctrl_q <= decode(nxt, opcode);
            if (state == S_FETCH)
                instr_cnt <= instr_cnt + CNT_W'(1);
            if (state == S_DECODE && nxt == S_FETCH)
                illegal_op <= 1'b1;
        end
    end

    // Gating by rst_n keeps every strobe low for the whole reset pulse.
    assign ctrl       = rst_n ? ctrl_q : '0;
    assign pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign state_o    = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed-vector bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
    logic [3:0]  state_o;
    logic [31:0] instr_cnt;
    logic        illegal_op;

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .state_o(state_o),
        .instr_cnt(instr_cnt), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // pe io mr mw iw rw reg_dst mem_to_reg asa asb alu_op pc_src
    logic [16:0] outs;
    assign outs = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

    localparam logic [16:0] O_ZERO   = 17'b0_0_0_0_0_0_00_00_0_00_00_00;
    localparam logic [16:0] O_FETCH  = 17'b1_0_1_0_1_0_00_00_0_01_00_00;
    localparam logic [16:0] O_DEC    = 17'b0_0_0_0_0_0_00_00_0_11_00_00;
    localparam logic [16:0] O_MADR   = 17'b0_0_0_0_0_0_00_00_1_10_00_00;
    localparam logic [16:0] O_MRD    = 17'b0_1_1_0_0_0_00_00_0_00_00_00;
    localparam logic [16:0] O_LWWB   = 17'b0_0_0_0_0_1_00_01_0_00_00_00;
    localparam logic [16:0] O_MWR    = 17'b0_1_0_1_0_0_00_00_0_00_00_00;
    localparam logic [16:0] O_REXE   = 17'b0_0_0_0_0_0_00_00_1_00_10_00;
    localparam logic [16:0] O_RWB    = 17'b0_0_0_0_0_1_01_00_0_00_00_00;
    localparam logic [16:0] O_BEQ_T  = 17'b1_0_0_0_0_0_00_00_1_00_01_01;
    localparam logic [16:0] O_BEQ_NT = 17'b0_0_0_0_0_0_00_00_1_00_01_01;
    localparam logic [16:0] O_JUMP   = 17'b1_0_0_0_0_0_00_00_0_00_00_10;
    localparam logic [16:0] O_JAL    = 17'b1_0_0_0_0_1_10_10_0_00_00_10;
    localparam logic [16:0] O_JR     = 17'b1_0_0_0_0_0_00_00_0_00_00_11;
    localparam logic [16:0] O_ADDI   = 17'b0_0_0_0_0_0_00_00_1_10_00_00;
    localparam logic [16:0] O_SLTI   = 17'b0_0_0_0_0_0_00_00_1_10_11_00;
    localparam logic [16:0] O_IWB    = 17'b0_0_0_0_0_1_00_00_0_00_00_00;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  cur   = 4'd0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] st, input logic [16:0] ov);
        cur = st;
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".outs"}, 32'(outs), 32'(ov));
        chk({tag, ".cnt"}, instr_cnt, exp_cnt);
    endtask

    task automatic go(input string tag, input logic [3:0] st, input logic [16:0] ov);
        if (cur == 4'd0) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_state(tag, st, ov);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'b100011; funct = 6'b000000; zero = 1'b0;
        #2;
        chk_state("rst", 4'd0, O_ZERO);
        chk("rst.ill", 32'(illegal_op), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_state("lw.f", 4'd0, O_FETCH);
        go("lw.d", 4'd1, O_DEC);
        go("lw.adr", 4'd2, O_MADR);
        go("lw.rd", 4'd3, O_MRD);
        go("lw.wb", 4'd4, O_LWWB);
        go("lw.f2", 4'd0, O_FETCH);
        opcode = 6'b000000; funct = 6'b100000;
        go("r.d", 4'd1, O_DEC);
        chk("cnt2", instr_cnt, 32'd2);
        go("r.exe", 4'd6, O_REXE);
        go("r.wb", 4'd7, O_RWB);
        go("r.f", 4'd0, O_FETCH);
        funct = 6'b001000;
        go("jr.d", 4'd1, O_DEC);
        go("jr", 4'd11, O_JR);
        go("jr.f", 4'd0, O_FETCH);

        opcode = 6'b000100;
        go("beq.d", 4'd1, O_DEC);
        zero = 1'b1; #1;
        go("beq.t", 4'd8, O_BEQ_T);
        zero = 1'b0; #1;
        chk("beq.nt", 32'(outs), 32'(O_BEQ_NT));
        go("beq.f", 4'd0, O_FETCH);

        opcode = 6'b101011;
        go("sw.d", 4'd1, O_DEC);
        go("sw.adr", 4'd2, O_MADR);
        go("sw.wr", 4'd5, O_MWR);
        go("sw.f", 4'd0, O_FETCH);
        opcode = 6'b000011;
        go("jal.d", 4'd1, O_DEC);
        go("jal", 4'd10, O_JAL);
        go("jal.f", 4'd0, O_FETCH);
        opcode = 6'b000010;
        go("j.d", 4'd1, O_DEC);
        go("j", 4'd9, O_JUMP);
        go("j.f", 4'd0, O_FETCH);
        opcode = 6'b001000;
        go("addi.d", 4'd1, O_DEC);
        go("addi", 4'd12, O_ADDI);
        go("addi.wb", 4'd13, O_IWB);
        go("addi.f", 4'd0, O_FETCH);
        opcode = 6'b001010;
        go("slti.d", 4'd1, O_DEC);
        go("slti", 4'd12, O_SLTI);
        go("slti.wb", 4'd13, O_IWB);
        go("slti.f", 4'd0, O_FETCH);

        opcode = 6'b111111;
        chk("ill.pre", 32'(illegal_op), 32'd0);
        go("ill.d", 4'd1, O_DEC);
        go("ill.f", 4'd0, O_FETCH);
        chk("ill.set", 32'(illegal_op), 32'd1);
        opcode = 6'b100011;
        go("lw2.d", 4'd1, O_DEC);
        go("lw2.adr", 4'd2, O_MADR);
        go("lw2.rd", 4'd3, O_MRD);
        chk("ill.sticky", 32'(illegal_op), 32'd1);

        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 32'd0;
        chk_state("arst", 4'd0, O_ZERO);
        chk("arst.ill", 32'(illegal_op), 32'd0);
        @(negedge clk);
        chk_state("arst.hold", 4'd0, O_ZERO);
        rst_n = 1'b1;
        #1;
        chk_state("rel.f", 4'd0, O_FETCH);

        force dut.instr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        go("wrap", 4'd1, O_DEC);
        chk("wrap.zero", instr_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS main controller. It sits directly upstream of the datapath's 32-bit 4-input select muxes and drives their 2-bit selects (ALU source B, PC source, write-back source, destination register), plus all write/read strobes. Outputs are Moore outputs decoded from the current state. The only exception is pc_en, which also uses the zero flag.

Parameters:
STATE_W, 4, state register width
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
pc_en  output  1  PC load enable = pc_write | (pc_write_cond & zero)
i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load
reg_write  output  1  register file write
reg_dst  output  2  00 rt, 01 rd, 10 r31
mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  output  1  0 PC, 1 A
alu_src_b  output  2  00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
alu_op  output  2  00 add, 01 sub, 10 funct-decode, 11 slt
pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A
state_o  output  STATE_W  current state (debug)
instr_cnt  output  CNT_W  count of FETCH cycles
illegal_op  output  1  sticky illegal-opcode flag

Behaviour:
- Opcodes:
  - R 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - jal 000011
  - addi 001000
  - slti 001010
- jr is R-type with funct 001000.
- States: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BEQ=8, JUMP=9, JAL=10, JR=11, I_EXE=12, I_WB=13. Codes 14–15 are unused and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEM_ADR (lw/sw), R_EXE (R, funct≠001000), JR (R, funct=001000), BEQ, JUMP, JAL, I_EXE (addi/slti). Any other opcode -> FETCH and sets illegal_op.
  - MEM_ADR -> MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD -> LW_WB.
  - R_EXE -> R_WB.
  - I_EXE -> I_WB.
  - LW_WB, MEM_WR, R_WB, BEQ, JUMP, JAL, JR -> FETCH.
- Every output not listed for a state is 0.
  - FETCH: mem_read, ir_write, pc_write=1; alu_src_a=0; alu_src_b=01; alu_op=00; pc_src=00.
  - DECODE: alu_src_a=0; alu_src_b=11; alu_op=00 (branch target into ALUOut).
  - MEM_ADR: alu_src_a=1; alu_src_b=10; alu_op=00.
  - MEM_RD: mem_read=1; i_or_d=1.
  - LW_WB: reg_write=1; reg_dst=00; mem_to_reg=01.
  - MEM_WR: mem_write=1; i_or_d=1.
  - R_EXE: alu_src_a=1; alu_src_b=00; alu_op=10.
  - R_WB: reg_write=1; reg_dst=01; mem_to_reg=00.
  - BEQ: alu_src_a=1; alu_src_b=00; alu_op=01; pc_write_cond=1; pc_src=01.
  - JUMP: pc_write=1; pc_src=10.
  - JAL: pc_write=1; pc_src=10; reg_write=1; reg_dst=10; mem_to_reg=10.
  - JR: pc_write=1; pc_src=11.
  - I_EXE: alu_src_a=1; alu_src_b=10; alu_op=00 (addi) or 11 (slti).
  - I_WB: reg_write=1; reg_dst=00; mem_to_reg=00.
- Reset:
  - rst_n low forces state=FETCH, instr_cnt=0 and illegal_op=0 immediately, without waiting for a clock edge.
  - While rst_n is low, all strobes and selects are forced to 0, including pc_en, mem_read and ir_write.
  - The first edge after release executes FETCH.
  - Reset asserted mid-instruction abandons the instruction; no strobe may glitch high.
- instr_cnt increments by 1 on every edge where state=FETCH and wraps 0xFFFFFFFF -> 0.
- illegal_op stays set until reset.
- Latencies in cycles: lw 5; sw, R-type, addi and slti 4; beq, j, jal and jr 3.

Test Plan:
- Release reset at t0 with opcode=100011 -> states 0,1,2,3,4,0; mem_read=1 in states 0 and 3; reg_write=1 only in state 4 with mem_to_reg=01; instr_cnt=2 after the second FETCH edge.
- opcode=000000, funct=100000 -> states 0,1,6,7; alu_op=10 in R_EXE; reg_dst=01 in R_WB. Repeat with funct=001000 -> states 0,1,11 with pc_src=11 and pc_en=1.
- opcode=000100 in BEQ: zero=1 -> pc_en=1, pc_src=01; zero=0 -> pc_en=0.
- opcode=000011 -> JAL outputs reg_dst=10, mem_to_reg=10, reg_write=1, pc_src=10.
- opcode=111111 -> DECODE returns to FETCH and illegal_op=1 persists; then an asynchronous rst_n pulse in MEM_RD of a lw -> state_o=0, all outputs 0, illegal_op=0 and instr_cnt=0 before the next clock edge.
- Force instr_cnt to 0xFFFFFFFF, then one FETCH edge -> instr_cnt=0.
